pb_event_arbiter: RTL and testbench
===================================

Name: pb_event_arbiter

Overview:
- Converts NUM_PB debounced push-button levels (1 = unpressed, 0 = pressed) into discrete PRESS, RELEASE and LONG events (plus REPEAT when the optional feature is compiled in).
- Shares one valid/ready event channel between all buttons using round-robin arbitration.
- Sits directly after the per-button debouncers and feeds UART/command logic that acts on button gestures.

Parameters:
- NUM_PB, 4: number of buttons; must be >= 2.
- LONG_PRESS_CYCLES, 50000000: number of held cycles after PRESS before LONG is emitted; must be >= 2.
- REPEAT_CYCLES, 10000000: auto-repeat period in the HELD state (used only with the optional feature); must be >= 2.
- ID_W, $clog2(NUM_PB): derived; do not modify.
- CNT_W, $clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES)+1): derived; do not modify.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- pb_db  in  NUM_PB  debounced, clk-synchronous button levels; 1 = unpressed.
- evt_valid  out  1  event present on the output channel.
- evt_ready  in  1  consumer accepts the event; a transfer occurs when evt_valid && evt_ready.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_type  out  2  event code: 0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT.
- ovf  out  1  sticky flag: a pending event was overwritten before it was granted.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: evt_valid=0, evt_id=0, evt_type=0, ovf=0.
  - Internal state: pb_prev=all 1, every button FSM in IDLE, every counter 0, every pending slot empty, round-robin pointer 0.
  - A button already held when reset is released produces PRESS on the first clock after release.
- Per-button FSM, evaluated independently for each button i:
  - IDLE: if pb_prev[i]=1 and pb_db[i]=0, write PRESS to the slot, clear the counter, go to PRESSED.
  - PRESSED: increment the counter each cycle. When the counter reaches LONG_PRESS_CYCLES-1, write LONG, clear the counter, go to HELD.
  - HELD: the counter is idle without the optional feature.
  - In PRESSED or HELD: if pb_db[i]=1, write RELEASE, clear the counter, go to IDLE. Release takes priority over LONG and REPEAT in the same cycle.
  - pb_prev is a 1-cycle registered copy of pb_db.
- Pending slot (one per button: valid bit + 2-bit type):
  - A write to an empty slot sets it.
  - A write to a full slot replaces the type (newest event wins) and sets ovf.
  - If a write and a grant of the same slot occur in the same cycle, the old content is granted, the new content stays pending, and ovf is not set.
  - ovf_clr clears ovf. If ovf_clr and a new overwrite occur in the same cycle, set wins.
- Output register and arbiter:
  - The output register loads when it is empty or a transfer occurs this cycle, giving full throughput.
  - Grant selection: scan slots starting at the pointer and wrapping modulo NUM_PB. The first full slot is granted: its contents move to evt_id/evt_type, evt_valid=1, the slot clears, and pointer = granted id + 1 (with wrap).
  - With no full slot, evt_valid drops after a transfer.
  - evt_id and evt_type are stable while evt_valid=1 and evt_ready=0.
- Latency: pb_db falling at edge N → slot written at edge N+1 → evt_valid=1 after edge N+2, assuming the channel is idle.
- Counters saturate-free: they are always cleared on a state change and never wrap.

Optional Feature:
- Macro: PB_AUTO_REPEAT_EN.
- Defined: in HELD, the counter increments. When it reaches REPEAT_CYCLES-1, write REPEAT to the slot and clear the counter. This repeats until release.
- Undefined: no REPEAT logic is generated; evt_type never equals 3; the HELD counter stays 0.

Test Plan:
(Parameters: NUM_PB=4, LONG=8, REPEAT=4.)
- Reset with all pb_db=1, evt_ready=1 → evt_valid=0 and ovf=0 for 20 cycles.
- pb_db[2] 1→0 at edge N, held 3 cycles, then 1 → PRESS (id=2, type=0) valid after edge N+2; RELEASE (id=2, type=1) follows; no LONG.
- pb_db[1]=0 held 12 cycles → PRESS, then LONG (type=2) 8 cycles after PRESS is written. With PB_AUTO_REPEAT_EN, REPEAT (type=3) follows every 4 cycles; without it, no further events until RELEASE.
- pb_db[0] and pb_db[3] fall on the same edge, evt_ready=1 → PRESS id=0, then PRESS id=3 on consecutive cycles; next simultaneous pair is granted 0 then 3 again, because the pointer=0 after wrap.
- evt_ready=0 while button 1 does press, release, press → outputs frozen; button 1's slot is overwritten → ovf=1. Pulse ovf_clr → ovf=0.
- Assert rst_n=0 mid-LONG count with evt_valid=1 → evt_valid=0 immediately; after release with pb_db[1]=0, a fresh PRESS id=1 is emitted.

Source files
------------

// File: rtl/pb_event_arbiter.sv
// pb_event_arbiter
// Turns debounced push-button levels (1 = unpressed, 0 = pressed) into PRESS,
// RELEASE and LONG gesture events. A round-robin arbiter merges them onto one
// valid/ready event channel.
// Build option: define PB_AUTO_REPEAT_EN to add periodic REPEAT events while a
// button stays in the HELD state. Without it the HELD counter stays at 0.
//
// Ports:
//   clk        single clock
//   rst_n      asynchronous active-low reset
//   pb_db      debounced, clk-synchronous button levels (1 = unpressed)
//   evt_valid  event present on the output channel
//   evt_ready  consumer accepts the event (transfer = evt_valid && evt_ready)
//   evt_id     index of the button that produced the event
//   evt_type   0 = PRESS, 1 = RELEASE, 2 = LONG, 3 = REPEAT
//   ovf        sticky: a pending event was overwritten before it was granted
//   ovf_clr    synchronous clear of ovf (a same-cycle overwrite wins)
module pb_event_arbiter #(
  parameter int unsigned NUM_PB            = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000,
  parameter int unsigned REPEAT_CYCLES     = 10000000,
  localparam int unsigned ID_W             = $clog2(NUM_PB),
  localparam int unsigned CNT_MAX          = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                             LONG_PRESS_CYCLES : REPEAT_CYCLES,
  localparam int unsigned CNT_W            = $clog2(CNT_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] pb_db,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [1:0]        evt_type,
  output logic              ovf,
  input  logic              ovf_clr
);

  // Per-button gesture states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  // Event codes
  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
`ifdef PB_AUTO_REPEAT_EN
  localparam logic [1:0] EVT_REPEAT  = 2'd3;
`endif

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`ifdef PB_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  // Registered state
  logic [NUM_PB-1:0]            pb_prev_q;
  logic [NUM_PB-1:0][1:0]       state_q,     state_d;
  logic [NUM_PB-1:0][CNT_W-1:0] cnt_q,       cnt_d;
  logic [NUM_PB-1:0]            slot_vld_q,  slot_vld_d;
  logic [NUM_PB-1:0][1:0]       slot_type_q, slot_type_d;
  logic [ID_W-1:0]              rr_ptr_q,    rr_ptr_d;
  logic                         evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]              evt_id_q,    evt_id_d;
  logic [1:0]                   evt_type_q,  evt_type_d;
  logic                         ovf_q,       ovf_d;

  // Combinational intermediates
  logic [NUM_PB-1:0]            wr_en;
  logic [NUM_PB-1:0][1:0]       wr_type;
  logic                         gnt_found;
  logic [ID_W-1:0]              gnt_id;
  logic                         load_en;
  logic [NUM_PB-1:0]            gnt_vec;
  logic                         ovf_set;

  // Modulo-NUM_PB add, so non-power-of-two button counts wrap correctly
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    return ID_W'(sum % NUM_PB);
  endfunction

  // Per-button gesture FSMs: decide next state, counter and slot write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = '0;
    wr_type = '0;
    for (int unsigned i = 0; i < NUM_PB; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (pb_prev_q[i] && !pb_db[i]) begin
            wr_en[i]   = 1'b1;
            wr_type[i] = EVT_PRESS;
            cnt_d[i]   = '0;
            state_d[i] = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // Release outranks LONG in the same cycle
          if (pb_db[i]) begin
            wr_en[i]   = 1'b1;
            wr_type[i] = EVT_RELEASE;
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == LONG_LAST) begin
            wr_en[i]   = 1'b1;
            wr_type[i] = EVT_LONG;
            cnt_d[i]   = '0;
            state_d[i] = ST_HELD;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_HELD: begin
          // Release outranks REPEAT in the same cycle
          if (pb_db[i]) begin
            wr_en[i]   = 1'b1;
            wr_type[i] = EVT_RELEASE;
            cnt_d[i]   = '0;
            state_d[i] = ST_IDLE;
          end
`ifdef PB_AUTO_REPEAT_EN
          else if (cnt_q[i] == REP_LAST) begin
            wr_en[i]   = 1'b1;
            wr_type[i] = EVT_REPEAT;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
          end
`endif
        end
        default: begin
          cnt_d[i]   = '0;
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Round-robin scan: first full slot at or after the pointer
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int unsigned k = 0; k < NUM_PB; k++) begin
      if (!gnt_found && slot_vld_q[wrap_add(rr_ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Pending slots, overflow flag, output register and pointer update
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_type_d = slot_type_q;
    rr_ptr_d    = rr_ptr_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_type_d  = evt_type_q;
    gnt_vec     = '0;
    ovf_set     = 1'b0;

    // Output refills when empty or draining this cycle
    load_en = !evt_valid_q || evt_ready;

    if (load_en) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_id_d   = gnt_id;
        evt_type_d = slot_type_q[gnt_id];
        rr_ptr_d   = wrap_add(gnt_id, 1);
      end
    end

    for (int unsigned i = 0; i < NUM_PB; i++) begin
      gnt_vec[i] = load_en && gnt_found && (gnt_id == ID_W'(i));
      if (gnt_vec[i]) begin
        slot_vld_d[i] = 1'b0;
      end
      // A write landing on a slot being granted this cycle is not an overwrite
      if (wr_en[i]) begin
        slot_vld_d[i]  = 1'b1;
        slot_type_d[i] = wr_type[i];
        if (slot_vld_q[i] && !gnt_vec[i]) begin
          ovf_set = 1'b1;
        end
      end
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_prev_q   <= '1;
      state_q     <= {NUM_PB{ST_IDLE}};
      cnt_q       <= '0;
      slot_vld_q  <= '0;
      slot_type_q <= '0;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_type_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      pb_prev_q   <= pb_db;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_type_q <= slot_type_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_type_q  <= evt_type_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_type  = evt_type_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Directed bench for pb_event_arbiter (NUM_PB=4, LONG=8, REPEAT=4).
module tb_pb_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] pb_db;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       ovf;
  logic       ovf_clr;

  int n_cmp;
  int n_err;

  pb_event_arbiter #(
    .NUM_PB            (4),
    .LONG_PRESS_CYCLES (8),
    .REPEAT_CYCLES     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pb_db     (pb_db),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // v=0: only evt_valid is checked; v=1: {valid,id,type} is checked
  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id,
                         input logic [1:0] ty);
    if (v) chk(tag, 32'({evt_valid, evt_id, evt_type}), 32'({1'b1, id, ty}));
    else   chk(tag, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    pb_db     = 4'hF;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset values
    tick();
    chk("reset_outputs", 32'({evt_valid, evt_id, evt_type, ovf}), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_quiet", 32'({evt_valid, ovf}), 32'd0);
    end

    // Simultaneous presses on 0 and 3, pointer at 0
    pb_db = 4'b0110;
    tick(); chk_evt("pair_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("pair_press0", 1'b1, 2'd0, 2'd0);
    tick(); chk_evt("pair_press3", 1'b1, 2'd3, 2'd0);
    tick(); chk_evt("pair_drain", 1'b0, 2'd0, 2'd0);
    pb_db = 4'hF;
    tick(); chk_evt("pair_rel_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("pair_rel0", 1'b1, 2'd0, 2'd1);
    tick(); chk_evt("pair_rel3", 1'b1, 2'd3, 2'd1);
    tick(); chk_evt("pair_rel_drain", 1'b0, 2'd0, 2'd0);
    chk("pair_ovf", 32'(ovf), 32'd0);

    // Short press on button 2: PRESS then RELEASE, no LONG
    pb_db[2] = 1'b0;
    tick(); chk_evt("short_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("short_press", 1'b1, 2'd2, 2'd0);
    tick(); chk_evt("short_drain", 1'b0, 2'd0, 2'd0);
    pb_db[2] = 1'b1;
    tick(); chk_evt("short_rel_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("short_release", 1'b1, 2'd2, 2'd1);
    for (int c = 0; c < 10; c++) begin
      tick(); chk_evt("short_no_long", 1'b0, 2'd0, 2'd0);
    end

    // Long press on button 1
    pb_db[1] = 1'b0;
    tick(); chk_evt("long_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("long_press", 1'b1, 2'd1, 2'd0);
    for (int c = 0; c < 7; c++) begin
      tick(); chk_evt("long_wait", 1'b0, 2'd0, 2'd0);
    end
    tick(); chk_evt("long_event", 1'b1, 2'd1, 2'd2);
    tick(); chk_evt("held_quiet_a", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("held_quiet_b", 1'b0, 2'd0, 2'd0);
`ifdef PB_AUTO_REPEAT_EN
    tick(); chk_evt("repeat_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("repeat_event", 1'b1, 2'd1, 2'd3);
`endif
    pb_db[1] = 1'b1;
    tick(); chk_evt("long_rel_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("long_release", 1'b1, 2'd1, 2'd1);
    tick(); chk_evt("long_rel_drain", 1'b0, 2'd0, 2'd0);

    // Backpressure: press, release, press on button 1 with evt_ready low
    evt_ready = 1'b0;
    pb_db[1]  = 1'b0;
    tick(); chk_evt("bp_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("bp_press", 1'b1, 2'd1, 2'd0);
    pb_db[1] = 1'b1;
    tick(); chk_evt("bp_frozen_a", 1'b1, 2'd1, 2'd0);
    chk("bp_no_ovf", 32'(ovf), 32'd0);
    pb_db[1] = 1'b0;
    tick(); chk_evt("bp_frozen_b", 1'b1, 2'd1, 2'd0);
    chk("bp_ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick(); chk("bp_ovf_clr", 32'(ovf), 32'd0);
    ovf_clr   = 1'b0;
    evt_ready = 1'b1;
    // Overwritten slot now holds the newer PRESS, not the RELEASE
    tick(); chk_evt("bp_newest_wins", 1'b1, 2'd1, 2'd0);

    // Async reset mid-count while an event is being presented
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({evt_valid, evt_id, evt_type, ovf}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick(); chk_evt("rst_slot_wr", 1'b0, 2'd0, 2'd0);
    tick(); chk_evt("rst_fresh_press", 1'b1, 2'd1, 2'd0);
    for (int c = 0; c < 7; c++) begin
      tick(); chk_evt("rst_long_wait", 1'b0, 2'd0, 2'd0);
    end
    tick(); chk_evt("rst_long_event", 1'b1, 2'd1, 2'd2);
    pb_db = 4'hF;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
